aclk_keyscan: RTL and testbench

Matrix-keypad scanner for the alarm clock: it produces the `key`, `alarm_button` and `time_button` inputs consumed by the alarm-clock top level. It drives the columns of a 4x3 keypad, samples the rows, rejects multi-key presses and debounces across whole scan frames. It holds a stable code for as long as the key stays pressed, and presents the no-key code (10) otherwise.

---
 rtl/aclk_pkg.sv | 13 +
 rtl/aclk_sync2.sv | 16 +
 rtl/aclk_keyscan.sv | 103 ++++++++++
 tb/tb_aclk_keyscan.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/aclk_pkg.sv
// aclk_pkg: shared keypad codes, matrix dimensions, debounce state type and keymap helper
package aclk_pkg;
   localparam logic [3:0] NOKEY = 4'd10;
   localparam logic [3:0] STAR  = 4'd11;
   localparam logic [3:0] HASH  = 4'd12;
   localparam int NUM_ROWS = 4;
   localparam int NUM_COLS = 3;
   typedef enum logic [1:0] {IDLE_NOKEY, HELD, LOCKOUT} db_state_t;
   // rows 0..2 hold digits 1..9 in reading order; the bottom row is * 0 #
   function automatic logic [3:0] key_code(input int r, input int c);
      return r < NUM_ROWS - 1 ? 4'(r * NUM_COLS + c + 1) : (c == 0 ? STAR : c == 1 ? 4'd0 : HASH);
   endfunction
endpackage

// File: rtl/aclk_sync2.sv
// aclk_sync2: 2-flop synchronizer
// Ports: clock, reset (async active-low), d (async input), q (synchronized output).
// Resets to all ones because the keypad rows idle high through their pull-ups.
module aclk_sync2 #(
   parameter int W = 1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   logic [W-1:0] meta;
   always_ff @(posedge clock or negedge reset)
      if (!reset) {q, meta} <= {{W{1'b1}}, {W{1'b1}}};
      else {q, meta} <= {meta, d};
endmodule

// File: rtl/aclk_keyscan.sv
// aclk_keyscan: 4x3 keypad scanner with multi-key rejection and whole-frame debounce
// Ports: clock; reset (async active-low); row[3:0] keypad rows, active-low, asynchronous;
//        col[2:0] one-hot active-low column drive; key = committed digit or 10;
//        alarm_button high while * is committed; time_button high while # is committed.
module aclk_keyscan
   import aclk_pkg::*;
#(
   parameter int SCAN_DIV       = 4,
   parameter int DEBOUNCE_SCANS = 3
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [NUM_ROWS-1:0] row,
   output logic [NUM_COLS-1:0] col,
   output logic [3:0]          key,
   output logic                alarm_button,
   output logic                time_button
);
   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [DW-1:0] LAST = DW'(SCAN_DIV - 1);
   localparam logic [CW-1:0] SAT  = CW'(DEBOUNCE_SCANS);

   logic [NUM_ROWS-1:0]                row_s;
   logic [DW-1:0]                      dwell;
   logic [1:0]                         col_idx;
   logic [NUM_COLS-2:0][NUM_ROWS-1:0]  acc;
   logic [NUM_COLS-1:0][NUM_ROWS-1:0]  hits;
   logic [3:0]                         n_hits, frame_dec, frame_code, cand, committed;
   logic                               sample, frame_valid, same, commit;
   logic [CW-1:0]                      cnt, cnt_nx;
   db_state_t                          state;

   aclk_sync2 #(.W(NUM_ROWS)) u_sync (.clock(clock), .reset(reset), .d(row), .q(row_s));

   assign sample = dwell == LAST;
   // column 2 is decoded straight from the synchronizer so the frame code lands one cycle after its sample
   assign hits = {~row_s, acc};

   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         dwell       <= '0;
         col_idx     <= '0;
         col         <= 3'b110;
         acc         <= '0;
         frame_valid <= 1'b0;
         frame_code  <= NOKEY;
      end else begin
         dwell       <= sample ? '0 : dwell + 1'b1;
         frame_valid <= sample && col_idx == 2'd2;
         if (sample) begin
            col_idx <= col_idx == 2'd2 ? 2'd0 : col_idx + 2'd1;
            col     <= {col[1:0], col[2]};
            if (col_idx == 2'd2) frame_code <= frame_dec;
            else acc[col_idx[0]] <= ~row_s;
         end
      end

   // anything other than exactly one intersection decodes as no key, so ghosts never surface
   always_comb begin
      n_hits    = '0;
      frame_dec = NOKEY;
      for (int c = 0; c < NUM_COLS; c++)
         for (int r = 0; r < NUM_ROWS; r++)
            if (hits[c][r]) begin
               n_hits    = n_hits + 4'd1;
               frame_dec = key_code(r, c);
            end
      if (n_hits != 4'd1) frame_dec = NOKEY;
   end

   assign same   = frame_code == cand;
   assign cnt_nx = !same ? CW'(1) : cnt == SAT ? cnt : cnt + 1'b1;
   assign commit = cnt_nx == SAT && frame_code != committed;

   // a direct key-to-key change first commits NOKEY so the controller always sees a release
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         state        <= IDLE_NOKEY;
         cand         <= NOKEY;
         committed    <= NOKEY;
         cnt          <= '0;
         key          <= NOKEY;
         alarm_button <= 1'b0;
         time_button  <= 1'b0;
      end else begin
         key          <= committed <= 4'd9 ? committed : NOKEY;
         alarm_button <= committed == STAR;
         time_button  <= committed == HASH;
         if (frame_valid) begin
            cand <= frame_code;
            cnt  <= cnt_nx;
            if (commit && state == HELD && frame_code != NOKEY) begin
               committed <= NOKEY;
               cnt       <= '0;
               state     <= LOCKOUT;
            end else if (commit) begin
               committed <= frame_code;
               state     <= frame_code == NOKEY ? IDLE_NOKEY : HELD;
            end
         end
      end
endmodule

// File: tb/tb_aclk_keyscan.sv
// tb_aclk_keyscan: randomized and directed self-checking bench for aclk_keyscan
module tb_aclk_keyscan;
   import aclk_pkg::*;
   localparam int SD    = 4;
   localparam int DS    = 3;
   localparam int FRAME = 3 * SD;
   localparam int LAT   = 2 + (DS + 1) * FRAME + 2;
   localparam int GAP   = DS * FRAME;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [11:0] pressed = '0;
   logic [3:0]  row;
   logic [2:0]  col;
   logic [3:0]  key;
   logic        alarm_button, time_button;
   int          n_chk = 0, n_pass = 0;
   logic [3:0]  kmap [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd11, 4'd0, 4'd12};

   aclk_keyscan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
      .clock(clock), .reset(reset), .row(row), .col(col),
      .key(key), .alarm_button(alarm_button), .time_button(time_button)
   );

   always #5 clock = ~clock;

   // passive keypad: a row is pulled low when a pressed key sits on the driven column
   always_comb begin
      row = '1;
      for (int r = 0; r < 4; r++) row[r] = ~|(pressed[r*3 +: 3] & ~col);
   end

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
   endtask

   function automatic logic [3:0] exp_code(input logic [11:0] p);
      if ($countones(p) != 1) return NOKEY;
      for (int i = 0; i < 12; i++) if (p[i]) return kmap[i];
      return NOKEY;
   endfunction

   function automatic logic [3:0] cur_code();
      return alarm_button ? STAR : time_button ? HASH : key;
   endfunction

   task automatic press(input logic [11:0] p);
      @(posedge clock);
      #1 pressed = p;
   endtask

   task automatic wait_code(input string tag, input logic [3:0] c, input int budget);
      int i = 0;
      @(negedge clock);
      while (cur_code() != c && i < budget) begin
         @(negedge clock);
         i++;
      end
      chk(tag, cur_code(), c);
   endtask

   // output-level rules: no direct code-to-code change, every press preceded by a full NOKEY gap
   logic [3:0] prev_oc = NOKEY;
   int         nk = 0;
   always @(negedge clock) begin
      if (!reset) begin
         prev_oc <= NOKEY;
         nk      <= 0;
      end else begin
         if (cur_code() != prev_oc) begin
            chk("buttons_excl", alarm_button & time_button, 0);
            chk("key_range", key <= 4'd10, 1);
            if (prev_oc != NOKEY && cur_code() != NOKEY) chk("direct_change", cur_code(), NOKEY);
            else if (cur_code() != NOKEY) chk("nokey_gap", nk >= GAP, 1);
         end
         prev_oc <= cur_code();
         nk      <= cur_code() == NOKEY ? nk + 1 : 0;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [2:0]  ecol;
      logic [11:0] p;
      logic [3:0]  m, nc;
      int          bad;
      repeat (3) @(negedge clock);
      chk("rst_col", col, 3'b110);
      chk("rst_key", key, 10);
      chk("rst_alarm", alarm_button, 0);
      chk("rst_time", time_button, 0);
      reset = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clock);
         ecol = ~(3'b001 << ((k / SD) % 3));
         chk("col_scan", col, ecol);
         chk("idle_code", cur_code(), NOKEY);
      end
      press(12'd1 << 4);
      wait_code("press_5", 4'd5, LAT);
      repeat (40) @(negedge clock);
      chk("hold_5", cur_code(), 5);
      press('0);
      wait_code("release_5", NOKEY, LAT);
      press(12'd1 << 9);
      wait_code("star", STAR, LAT);
      chk("star_key", key, 10);
      press('0);
      wait_code("release_star", NOKEY, LAT);
      press(12'd1 << 11);
      wait_code("hash", HASH, LAT);
      chk("hash_time", time_button, 1);
      press('0);
      wait_code("release_hash", NOKEY, LAT);
      press(12'b11);
      bad = 0;
      repeat (LAT + 2 * FRAME) begin
         @(negedge clock);
         if (cur_code() != NOKEY) bad++;
      end
      chk("multi_1_2", bad, 0);
      press('0);
      for (int i = 0; i < 12; i++) begin
         repeat (4) @(posedge clock);
         press(pressed ^ (12'd1 << 6));
      end
      press(12'd1 << 6);
      wait_code("bounce_7", 4'd7, LAT);
      press('0);
      wait_code("release_7", NOKEY, LAT);
      press(12'd1 << 2);
      wait_code("roll_3", 4'd3, LAT);
      press(12'd1 << 5);
      wait_code("roll_release", NOKEY, LAT);
      wait_code("roll_6", 4'd6, LAT);
      press('0);
      wait_code("release_6", NOKEY, LAT);
      press(12'd1 << 7);
      wait_code("press_8", 4'd8, LAT);
      repeat ($urandom_range(0, 11)) @(posedge clock);
      @(posedge clock);
      #2 reset = 1'b0;
      #1;
      chk("async_rst_key", key, 10);
      chk("async_rst_alarm", alarm_button, 0);
      chk("async_rst_time", time_button, 0);
      chk("async_rst_col", col, 3'b110);
      @(negedge clock);
      reset = 1'b1;
      wait_code("recommit_8", 4'd8, LAT);
      m = 4'd8;
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 9))
            0:       p = '0;
            1, 2:    p = (12'd1 << $urandom_range(0, 11)) | (12'd1 << $urandom_range(0, 11));
            default: p = 12'd1 << $urandom_range(0, 11);
         endcase
         nc = exp_code(p);
         press(p);
         if (m != NOKEY && nc != NOKEY && nc != m) begin
            wait_code("rnd_lockout", NOKEY, LAT);
            wait_code("rnd_roll", nc, LAT);
         end else wait_code("rnd_settle", nc, LAT);
         repeat ($urandom_range(0, 30)) @(negedge clock);
         chk("rnd_hold", cur_code(), nc);
         m = nc;
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
